pulse_filter_multi: RTL and testbench
=====================================

Name: pulse_filter_multi

Overview:
- Parametrised multi-channel successor to the single-channel debounce filter.
- Each channel has:
  - an input synchroniser;
  - separate rise and fall filter thresholds;
  - a per-channel bypass;
  - one-cycle edge strobes;
  - a sticky glitch flag.
- Sits between raw GPIO/sensor pins and downstream logic that consumes clean levels and edge events.
- Time unit is one clk period (50 ns at 20 MHz).

Parameters:
- CH_NUM, 8, number of independent channels (1..32).
- CNT_W, 22, counter/threshold width (22 bits covers 200 ms at 50 ns).
- SYNC_STAGES, 2, synchroniser flop depth (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pulse_in  input  CH_NUM  raw asynchronous inputs, one bit per channel.
- rise_thres  input  CNT_W  0->1 filter threshold, shared by all channels.
- fall_thres  input  CNT_W  1->0 filter threshold, shared by all channels.
- filter_en  input  CH_NUM  1 = filter active, 0 = bypass, per channel.
- glitch_clr  input  CH_NUM  per-channel clear of glitch_flag, level-sensitive.
- pulse_out  output  CH_NUM  filtered levels.
- rise_pulse  output  CH_NUM  one-cycle strobe when pulse_out rises.
- fall_pulse  output  CH_NUM  one-cycle strobe when pulse_out falls.
- glitch_flag  output  CH_NUM  sticky: a rejected transition occurred.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on rst_n.
  - All synchroniser flops, counters, pulse_out, rise_pulse, fall_pulse and glitch_flag are 0.
  - Reset mid-count discards the count. After release, the channel restarts from pulse_out=0.
- Synchroniser: pulse_in[i] passes through SYNC_STAGES flops; the last flop output is s[i]. All filtering uses s[i].
- Threshold selection: thr = rise_thres when pulse_out[i]=0, fall_thres when pulse_out[i]=1. Thresholds are sampled live every cycle.
- Filter, when filter_en[i]=1, evaluated each clock:
  - s!=out and cnt<thr: cnt<=cnt+1.
  - s!=out and cnt>=thr: out<=s, cnt<=0, corresponding edge strobe <=1.
  - s==out: cnt<=0. If cnt!=0 in that cycle, glitch_flag<=1 (the mismatch ended before acceptance).
- Latency:
  - A stable change on s is accepted thr+1 clocks after s first differs from out.
  - thr=0 gives a 1-clock filter.
  - End-to-end latency from pulse_in is SYNC_STAGES+thr+1 clocks.
- Threshold changed mid-count: the new value applies immediately. If cnt>=new thr, acceptance occurs on that clock. The counter never wraps, because it stops at thr.
- Max threshold: thr=2^CNT_W-1 is legal. cnt saturates at thr, so no overflow.
- Bypass, when filter_en[i]=0:
  - out<=s every clock and cnt<=0.
  - Edge strobes are still generated on out changes.
  - glitch_flag is not set.
- Switching filter_en 1->0 mid-count: cnt is discarded and out follows s on the next clock. A glitch is not flagged.
- Switching 0->1: filtering starts from the current out.
- Edge strobes: rise_pulse/fall_pulse are registered and high exactly one clock, the same cycle pulse_out shows the new level. They are never both high on one channel.
- glitch_flag:
  - Sticky until glitch_clr[i]=1.
  - If set and clear occur on the same clock, set wins and the flag stays 1.
- Channels are fully independent; there is no cross-channel interaction.

Decomposition:
- Shared package pulse_filter_pkg holds:
  - default CNT_W (22);
  - default SYNC_STAGES (2);
  - localparam constants for the 200 ms / 10 ms threshold presets (4_000_000, 200_000).
- Natural sub-module: pulse_filter_chan. It covers one channel: synchroniser, counter, threshold select, strobes and glitch flag.
- The top instantiates CH_NUM copies in a generate loop and only routes buses.

Test Plan:
- Reset release:
  - Stimulus: all pulse_in=0, rise_thres=5, fall_thres=3, filter_en=all 1.
  - Required response: all outputs remain 0 for 20 clocks.
- Clean rise:
  - Stimulus: ch0 pulse_in 0->1 held, rise_thres=5.
  - Required response: pulse_out[0] rises exactly 2+5+1=8 clocks after the input edge. rise_pulse[0] is high for that single clock.
  - Then 1->0 held with fall_thres=3: pulse_out[0] falls at 6 clocks, with fall_pulse[0] for one clock.
- Glitch rejection:
  - Stimulus: ch1 pulse_in high for 4 clocks, rise_thres=5.
  - Required response: pulse_out[1] stays 0, glitch_flag[1]=1 and stays 1.
  - Then glitch_clr[1]=1 for one clock: flag returns to 0. Repeating the glitch with glitch_clr held high leaves the flag at 1 (set wins).
- Bypass and thr=0:
  - Stimulus: ch2 filter_en=0, 1-clock pulse on pulse_in.
  - Required response: pulse_out[2] shows a 1-clock pulse 3 clocks later, with rise_pulse then fall_pulse. No glitch_flag.
  - Then filter_en=1, rise_thres=0: a 1-clock high input is accepted.
- Threshold shrink mid-count:
  - Stimulus: rise_thres=100. Hold input high until cnt=50, then write rise_thres=10.
  - Required response: pulse_out rises on the next clock.
- Independence and reset mid-count:
  - Stimulus: drive ch0/ch7 with different patterns simultaneously.
  - Required response: outputs match a per-channel reference model.
  - Stimulus: assert rst_n=0 mid-count.
  - Required response: all outputs 0 immediately, and counting restarts from 0 after release.

Source files
------------

// File: rtl/pulse_filter_pkg.sv
// Shared constants and edge classification for the multi-channel pulse filter.
package pulse_filter_pkg;

    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Threshold presets in clk periods at 20 MHz.
    localparam int unsigned THR_200MS = 4_000_000;
    localparam int unsigned THR_10MS  = 200_000;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_e;

    function automatic edge_e edge_of(input logic prev, input logic nxt);
        if (!prev && nxt) begin
            return EDGE_RISE;
        end else if (prev && !nxt) begin
            return EDGE_FALL;
        end
        return EDGE_NONE;
    endfunction

endpackage

// File: rtl/pulse_filter_chan.sv
// One filter channel: input synchroniser, rise/fall threshold counter,
// bypass, registered edge strobes and sticky glitch flag.
module pulse_filter_chan
    import pulse_filter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] rise_thres,
    input  logic [CNT_W-1:0] fall_thres,
    input  logic             filter_en,
    input  logic             glitch_clr,
    output logic             pulse_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch_flag
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   glitch_q, glitch_d;

    logic             s;
    logic [CNT_W-1:0] thr;
    logic             glitch_set;
    edge_e            edge_kind;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pulse_in};
        s          = sync_q[SYNC_STAGES-1];
        thr        = out_q ? fall_thres : rise_thres;
        out_d      = out_q;
        cnt_d      = '0;
        glitch_set = 1'b0;

        // The counter only advances while below thr, so it can never wrap.
        if (!filter_en) begin
            out_d = s;
        end else if (s != out_q) begin
            if (cnt_q < thr) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                out_d = s;
            end
        end else begin
            glitch_set = (cnt_q != '0);
        end

        edge_kind = edge_of(out_q, out_d);
        rise_d    = (edge_kind == EDGE_RISE);
        fall_d    = (edge_kind == EDGE_FALL);
        glitch_d  = glitch_set | (glitch_q & ~glitch_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign pulse_out   = out_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign glitch_flag = glitch_q;

endmodule

// File: rtl/pulse_filter_multi.sv
// Multi-channel debounce filter: CH_NUM independent pulse_filter_chan
// instances sharing the rise/fall thresholds.
module pulse_filter_multi
    import pulse_filter_pkg::*;
#(
    parameter int unsigned CH_NUM      = 8,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] pulse_in,
    input  logic [CNT_W-1:0]  rise_thres,
    input  logic [CNT_W-1:0]  fall_thres,
    input  logic [CH_NUM-1:0] filter_en,
    input  logic [CH_NUM-1:0] glitch_clr,
    output logic [CH_NUM-1:0] pulse_out,
    output logic [CH_NUM-1:0] rise_pulse,
    output logic [CH_NUM-1:0] fall_pulse,
    output logic [CH_NUM-1:0] glitch_flag
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        pulse_filter_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .pulse_in    (pulse_in[i]),
            .rise_thres  (rise_thres),
            .fall_thres  (fall_thres),
            .filter_en   (filter_en[i]),
            .glitch_clr  (glitch_clr[i]),
            .pulse_out   (pulse_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .glitch_flag (glitch_flag[i])
        );
    end

endmodule

// File: tb/tb_pulse_filter_multi.sv
// Directed bench for pulse_filter_multi with a per-channel reference model
// checked every cycle, plus hand-computed latency/flag expectations.
module tb_pulse_filter_multi;

    localparam int CH = 8;
    localparam int CW = 22;
    localparam int SS = 2;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] pulse_in;
    logic [CW-1:0] rise_thres;
    logic [CW-1:0] fall_thres;
    logic [CH-1:0] filter_en;
    logic [CH-1:0] glitch_clr;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] glitch_flag;

    int checks;
    int errors;
    int cyc;

    pulse_filter_multi #(
        .CH_NUM      (CH),
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .rise_thres  (rise_thres),
        .fall_thres  (fall_thres),
        .filter_en   (filter_en),
        .glitch_clr  (glitch_clr),
        .pulse_out   (pulse_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_flag (glitch_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the filtered level flips once the synchronised input
    // has disagreed with it for more than thr consecutive cycles; a
    // disagreement run that ends earlier is a glitch.
    logic [CH-1:0] hist [SS];
    logic [CH-1:0] m_out, m_rise, m_fall, m_glitch;
    int            m_run [CH];

    always @(posedge clk or negedge rst_n) begin
        logic s_m;
        logic nxt_m;
        int   thr_m;
        logic gl_m;
        if (!rst_n) begin
            for (int k = 0; k < SS; k++) hist[k] = '0;
            m_out = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                s_m   = hist[SS-1][c];
                thr_m = m_out[c] ? int'(fall_thres) : int'(rise_thres);
                nxt_m = m_out[c];
                gl_m  = 1'b0;
                if (!filter_en[c]) begin
                    nxt_m    = s_m;
                    m_run[c] = 0;
                end else if (s_m != m_out[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] > thr_m) begin
                        nxt_m    = s_m;
                        m_run[c] = 0;
                    end
                end else begin
                    gl_m     = (m_run[c] > 0);
                    m_run[c] = 0;
                end
                m_rise[c]   = nxt_m & ~m_out[c];
                m_fall[c]   = ~nxt_m & m_out[c];
                m_glitch[c] = gl_m | (m_glitch[c] & ~glitch_clr[c]);
                m_out[c]    = nxt_m;
            end
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pulse_in;
        end
    end

    task automatic chkv(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chkv("pulse_out",   pulse_out,   m_out);
        chkv("rise_pulse",  rise_pulse,  m_rise);
        chkv("fall_pulse",  fall_pulse,  m_fall);
        chkv("glitch_flag", glitch_flag, m_glitch);
        chkv("rise_and_fall", rise_pulse & fall_pulse, '0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until pulse_out[ch]==val; n = ticks taken, -1 if the bound expires.
    task automatic wait_for(input int ch, input logic val, output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (pulse_out[ch] == val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int   n;
        logic seen;
        int   hi_cnt;
        int   first_hi;
        checks = 0; errors = 0; cyc = 0;
        rst_n      = 1'b0;
        pulse_in   = '0;
        rise_thres = CW'(5);
        fall_thres = CW'(3);
        filter_en  = '1;
        glitch_clr = '0;
        ticks(3);
        rst_n = 1'b1;

        ticks(20);
        chkv("reset_out_idle",    pulse_out,   '0);
        chkv("reset_glitch_idle", glitch_flag, '0);

        // Clean rise then fall on ch0: 2+5+1 and 2+3+1 clocks.
        pulse_in[0] = 1'b1;
        wait_for(0, 1'b1, n);
        chk_int("ch0_rise_latency", n, 8);
        chk_int("ch0_rise_strobe", int'(rise_pulse[0]), 1);
        tick();
        chk_int("ch0_rise_strobe_end", int'(rise_pulse[0]), 0);
        ticks(3);
        pulse_in[0] = 1'b0;
        wait_for(0, 1'b0, n);
        chk_int("ch0_fall_latency", n, 6);
        chk_int("ch0_fall_strobe", int'(fall_pulse[0]), 1);
        tick();
        chk_int("ch0_fall_strobe_end", int'(fall_pulse[0]), 0);

        // Glitch on ch1: 4 clocks high against rise threshold 5.
        pulse_in[1] = 1'b1;
        ticks(4);
        pulse_in[1] = 1'b0;
        ticks(8);
        chk_int("ch1_glitch_out", int'(pulse_out[1]), 0);
        chk_int("ch1_glitch_flag", int'(glitch_flag[1]), 1);
        ticks(5);
        chk_int("ch1_glitch_sticky", int'(glitch_flag[1]), 1);
        glitch_clr[1] = 1'b1;
        tick();
        glitch_clr[1] = 1'b0;
        tick();
        chk_int("ch1_glitch_cleared", int'(glitch_flag[1]), 0);
        glitch_clr[1] = 1'b1;
        pulse_in[1]   = 1'b1;
        seen          = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) pulse_in[1] = 1'b0;
            tick();
            seen = seen | glitch_flag[1];
        end
        chk_int("ch1_set_wins", int'(seen), 1);
        glitch_clr[1] = 1'b0;

        // Bypass on ch2: single-clock pulse reproduced 3 clocks later.
        filter_en[2] = 1'b0;
        pulse_in[2]  = 1'b1;
        hi_cnt = 0; first_hi = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            pulse_in[2] = 1'b0;
            if (pulse_out[2]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk_int("ch2_bypass_delay", first_hi, 3);
        chk_int("ch2_bypass_width", hi_cnt, 1);
        chk_int("ch2_bypass_no_glitch", int'(glitch_flag[2]), 0);

        // thr=0: a single high clock is accepted.
        filter_en[2] = 1'b1;
        rise_thres   = '0;
        pulse_in[2]  = 1'b1;
        tick();
        pulse_in[2] = 1'b0;
        wait_for(2, 1'b1, n);
        chk_int("ch2_thr0_accept", n, 2);
        wait_for(2, 1'b0, n);
        chk_int("ch2_thr0_fall", n, 4);
        rise_thres = CW'(5);
        ticks(2);

        // Threshold shrink mid-count on ch3.
        rise_thres  = CW'(100);
        pulse_in[3] = 1'b1;
        ticks(52);
        chk_int("ch3_pre_shrink", int'(pulse_out[3]), 0);
        rise_thres = CW'(10);
        wait_for(3, 1'b1, n);
        chk_int("ch3_shrink_accept", n, 1);
        rise_thres  = CW'(5);
        pulse_in[3] = 1'b0;
        wait_for(3, 1'b0, n);
        chk_int("ch3_fall", n, 6);

        // Maximum threshold holds off acceptance; shrinking it accepts at once.
        rise_thres  = '1;
        pulse_in[4] = 1'b1;
        ticks(30);
        chk_int("ch4_max_thr_hold", int'(pulse_out[4]), 0);
        rise_thres = CW'(5);
        wait_for(4, 1'b1, n);
        chk_int("ch4_max_thr_release", n, 1);
        pulse_in[4] = 1'b0;
        wait_for(4, 1'b0, n);
        chk_int("ch4_fall", n, 6);

        // Independent patterns on ch0 and ch7.
        for (int i = 0; i < 72; i++) begin
            pulse_in[0] = ((i / 9) % 2) == 1;
            pulse_in[7] = (i % 7) < 3;
            tick();
        end
        chk_int("ch0_no_glitch", int'(glitch_flag[0]), 0);
        chk_int("ch7_glitch", int'(glitch_flag[7]), 1);

        // Reset mid-count on ch5.
        pulse_in    = '0;
        pulse_in[5] = 1'b1;
        ticks(4);
        #1 rst_n = 1'b0;
        #1;
        chkv("async_reset_out",    pulse_out,   '0);
        chkv("async_reset_rise",   rise_pulse,  '0);
        chkv("async_reset_fall",   fall_pulse,  '0);
        chkv("async_reset_glitch", glitch_flag, '0);
        tick();
        rst_n = 1'b1;
        wait_for(5, 1'b1, n);
        chk_int("ch5_restart_latency", n, 8);
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
